// File: rtl/pzcorebus_pattern_master.sv
// Programmable pzcorebus traffic source: quiet when idle, on start issues a strided
// READ or non-posted WRITE sequence with patterned data and tracks responses.
package pzcorebus_pkg;
  typedef enum logic [3:0] {
    PZCOREBUS_NULL_COMMAND     = 4'b0000,
    PZCOREBUS_READ             = 4'b0001,
    PZCOREBUS_WRITE            = 4'b0010,
    PZCOREBUS_WRITE_NON_POSTED = 4'b0011
  } pzcorebus_command_type;
endpackage

interface pzcorebus_if #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int LENGTH_WIDTH  = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int PARAM_WIDTH   = 8,
  parameter int INFO_WIDTH    = 4
);
  logic                                      scmd_accept;
  logic                                      mcmd_valid;
  pzcorebus_pkg::pzcorebus_command_type      mcmd;
  logic [ID_WIDTH-1:0]                       mid;
  logic [ADDRESS_WIDTH-1:0]                  maddr;
  logic [LENGTH_WIDTH-1:0]                   mlength;
  logic [PARAM_WIDTH-1:0]                    mparam;
  logic [INFO_WIDTH-1:0]                     minfo;
  logic                                      sdata_accept;
  logic                                      mdata_valid;
  logic [DATA_WIDTH-1:0]                     mdata;
  logic [DATA_WIDTH/8-1:0]                   mdata_byteen;
  logic                                      mdata_last;
  logic                                      mresp_accept;
  logic                                      sresp_valid;
  logic [1:0]                                sresp;
  logic [ID_WIDTH-1:0]                       sid;
  logic                                      sresp_error;
  logic [DATA_WIDTH-1:0]                     sdata;
  logic                                      sresp_last;

  modport master (
    input  scmd_accept, sdata_accept, sresp_valid, sresp, sid, sresp_error, sdata, sresp_last,
    output mcmd_valid, mcmd, mid, maddr, mlength, mparam, minfo,
    output mdata_valid, mdata, mdata_byteen, mdata_last, mresp_accept
  );
  modport slave (
    output scmd_accept, sdata_accept, sresp_valid, sresp, sid, sresp_error, sdata, sresp_last,
    input  mcmd_valid, mcmd, mid, maddr, mlength, mparam, minfo,
    input  mdata_valid, mdata, mdata_byteen, mdata_last, mresp_accept
  );
endinterface

module pzcorebus_pattern_master
  import pzcorebus_pkg::*;
#(
  parameter int          COUNT_WIDTH     = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          ADDR_STRIDE     = 64,
  parameter int          MID_VALUE       = 0,
  parameter logic [31:0] DATA_SEED       = 32'hA5A5_0000,
  // must match the widths of the connected pzcorebus_if; DATA_WIDTH a multiple of 32
  parameter int          ID_WIDTH        = 4,
  parameter int          ADDRESS_WIDTH   = 32,
  parameter int          LENGTH_WIDTH    = 8,
  parameter int          DATA_WIDTH      = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_write,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [COUNT_WIDTH-1:0]   i_count,
  input  logic [LENGTH_WIDTH-1:0]  i_length,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [COUNT_WIDTH-1:0]   o_resp_count,
  output logic                     o_error,
  pzcorebus_if.master              master_if
);
  typedef enum logic [2:0] {IDLE, CMD, DATA, DRAIN, DONE} state_e;

  state_e                   state_q, state_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0]   k_q, k_d;
  logic [LENGTH_WIDTH-1:0]  len_q, len_d;
  logic [LENGTH_WIDTH-1:0]  beat_q, beat_d;
  logic [7:0]               outst_q, outst_d;
  logic [COUNT_WIDTH-1:0]   resp_count_q, resp_count_d;
  logic                     error_q, error_d;

  logic                     cmd_valid, data_valid;
  logic                     cmd_fire, data_fire, resp_fire, last_beat;
  logic [LENGTH_WIDTH-1:0]  eff_len;
  logic [COUNT_WIDTH-1:0]   cur_k;
  logic [31:0]              pattern;
  logic                     unused_resp;

  assign eff_len    = (i_length == '0) ? LENGTH_WIDTH'(1) : i_length;
  assign cmd_valid  = (state_q == CMD) && (outst_q < 8'(MAX_OUTSTANDING));
  assign data_valid = (state_q == DATA);
  assign cmd_fire   = cmd_valid & master_if.scmd_accept;
  assign data_fire  = data_valid & master_if.sdata_accept;
  assign resp_fire  = master_if.sresp_valid & master_if.sresp_last;
  assign last_beat  = (beat_q == len_q - LENGTH_WIDTH'(1));
  // k_q has already advanced past the command whose data is being sent
  assign cur_k      = k_q - COUNT_WIDTH'(1);
  assign pattern    = DATA_SEED + (32'(cur_k) << 8) + 32'(beat_q);
  assign unused_resp = ^{master_if.sresp, master_if.sid, master_if.sdata};

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    addr_d       = addr_q;
    count_d      = count_q;
    k_d          = k_q;
    len_d        = len_q;
    beat_d       = beat_q;
    outst_d      = outst_q;
    resp_count_d = resp_count_q;
    error_d      = error_q;

    if (cmd_fire && !resp_fire) begin
      outst_d = outst_q + 8'd1;
    end else if (!cmd_fire && resp_fire && (outst_q != '0)) begin
      outst_d = outst_q - 8'd1;
    end
    if (resp_fire && (resp_count_q != '1)) begin
      resp_count_d = resp_count_q + COUNT_WIDTH'(1);
    end
    if (master_if.sresp_valid && master_if.sresp_error) begin
      error_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_count == '0) begin
            state_d = DONE;
          end else begin
            write_d      = i_write;
            addr_d       = i_base_addr;
            count_d      = i_count;
            k_d          = '0;
            len_d        = eff_len;
            resp_count_d = '0;
            error_d      = 1'b0;
            state_d      = CMD;
          end
        end
      end
      CMD: begin
        if (cmd_fire) begin
          k_d    = k_q + COUNT_WIDTH'(1);
          addr_d = addr_q + ADDRESS_WIDTH'(ADDR_STRIDE);
          beat_d = '0;
          if (write_q)           state_d = DATA;
          else if (k_d < count_q) state_d = CMD;
          else                   state_d = DRAIN;
        end
      end
      DATA: begin
        if (data_fire) begin
          beat_d = beat_q + LENGTH_WIDTH'(1);
          if (last_beat) state_d = (k_q < count_q) ? CMD : DRAIN;
        end
      end
      // leave as soon as the final response is accepted so o_done follows it by one cycle
      DRAIN:   if (outst_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
      k_q          <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      outst_q      <= '0;
      resp_count_q <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      k_q          <= k_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      outst_q      <= outst_d;
      resp_count_q <= resp_count_d;
      error_q      <= error_d;
    end
  end

  assign master_if.mcmd_valid   = cmd_valid;
  assign master_if.mcmd         = (state_q != CMD) ? PZCOREBUS_NULL_COMMAND :
                                  write_q ? PZCOREBUS_WRITE_NON_POSTED : PZCOREBUS_READ;
  assign master_if.mid          = ID_WIDTH'(MID_VALUE);
  assign master_if.maddr        = (state_q == CMD) ? addr_q : '0;
  assign master_if.mlength      = (state_q == CMD) ? len_q : '0;
  assign master_if.mparam       = '0;
  assign master_if.minfo        = '0;
  assign master_if.mdata_valid  = data_valid;
  assign master_if.mdata        = data_valid ? {(DATA_WIDTH/32){pattern}} : '0;
  assign master_if.mdata_byteen = data_valid ? '1 : '0;
  assign master_if.mdata_last   = data_valid & last_beat;
  assign master_if.mresp_accept = 1'b1;

  assign o_busy       = (state_q == CMD) || (state_q == DATA) || (state_q == DRAIN);
  assign o_done       = (state_q == DONE);
  assign o_resp_count = resp_count_q;
  assign o_error      = error_q;
endmodule

// File: tb/tb_pzcorebus_pattern_master.sv
// Bench for pzcorebus_pattern_master: a reactive slave plus a transaction-level
// model (expected command/beat queues, outstanding and response counters).
module tb_pzcorebus_pattern_master;
  import pzcorebus_pkg::*;

  localparam int          CW   = 16;
  localparam int          MAXO = 4;
  localparam int          STR  = 64;
  localparam int          AW   = 32;
  localparam int          LW   = 8;
  localparam int          DW   = 64;
  localparam int          IW   = 4;
  localparam int          MIDV = 3;
  localparam logic [31:0] SEED = 32'hA5A5_0000;
  localparam int          RESP_DELAY = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, write;
  logic [AW-1:0] base;
  logic [CW-1:0] count;
  logic [LW-1:0] len;
  logic          busy, done, err;
  logic [CW-1:0] rcnt;

  pzcorebus_if #(.ID_WIDTH(IW), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW), .DATA_WIDTH(DW)) bus ();

  pzcorebus_pattern_master #(
    .COUNT_WIDTH(CW), .MAX_OUTSTANDING(MAXO), .ADDR_STRIDE(STR), .MID_VALUE(MIDV),
    .DATA_SEED(SEED), .ID_WIDTH(IW), .ADDRESS_WIDTH(AW), .LENGTH_WIDTH(LW), .DATA_WIDTH(DW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_write(write), .i_base_addr(base),
    .i_count(count), .i_length(len), .o_busy(busy), .o_done(done),
    .o_resp_count(rcnt), .o_error(err), .master_if(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // slave behaviour knobs set by the directed sequence
  int acc_mode  = 0;       // 0 always accept, 1 toggle, 2 never
  bit withhold  = 1'b0;
  bit err_mode  = 1'b0;
  bit stray_req = 1'b0;

  // model state
  bit            active = 1'b0, done_due = 1'b0, first_pending = 1'b0;
  int            m_out = 0, m_rcnt = 0, start_cyc = 0, done_cnt = 0;
  bit            m_err = 1'b0;
  logic [3:0]    exp_cmd_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [LW-1:0] exp_len_q[$];
  logic [DW-1:0] exp_data_q[$];
  bit            exp_last_q[$];
  int            resp_q[$];

  // observation logs for hand-computed checks
  logic [3:0]    obs_cmd[$];
  logic [AW-1:0] obs_addr[$];
  logic [LW-1:0] obs_len[$];
  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin : slave_and_compare
    bit            c_stall, d_stall, clr, start_ok;
    logic [43:0]   c_saved;
    logic [DW:0]   d_saved;
    logic [3:0]    ecmd;
    int            eff;
    c_stall = 1'b0; d_stall = 1'b0;
    bus.scmd_accept = 1'b0; bus.sdata_accept = 1'b0; bus.sresp_valid = 1'b0;
    bus.sresp = '0; bus.sid = '0; bus.sresp_error = 1'b0; bus.sdata = '0; bus.sresp_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      check("mresp_accept", 64'(bus.mresp_accept), 64'd1);
      if (rst) begin
        bus.scmd_accept = 1'b0; bus.sdata_accept = 1'b0;
        bus.sresp_valid = 1'b0; bus.sresp_last = 1'b0; bus.sresp_error = 1'b0;
        active = 1'b0; done_due = 1'b0; first_pending = 1'b0;
        m_out = 0; m_rcnt = 0; m_err = 1'b0; c_stall = 1'b0; d_stall = 1'b0;
        exp_cmd_q.delete(); exp_addr_q.delete(); exp_len_q.delete();
        exp_data_q.delete(); exp_last_q.delete(); resp_q.delete();
        continue;
      end
      check("o_done", 64'(done), 64'(done_due));
      check("o_busy", 64'(busy), 64'(active && !done_due));
      check("o_resp_count", 64'(rcnt), 64'(m_rcnt));
      check("o_error", 64'(err), 64'(m_err));
      if (done) done_cnt++;
      check("cmd_data_overlap", 64'(bus.mcmd_valid & bus.mdata_valid), 64'd0);
      if (!active || done_due) begin
        check("idle_mcmd_valid", 64'(bus.mcmd_valid), 64'd0);
        check("idle_mdata_valid", 64'(bus.mdata_valid), 64'd0);
      end
      if (m_out >= MAXO) check("outstanding_limit", 64'(bus.mcmd_valid), 64'd0);
      if (c_stall) begin
        check("cmd_hold_valid", 64'(bus.mcmd_valid), 64'd1);
        check("cmd_hold_payload", 64'({bus.mcmd, bus.maddr, bus.mlength}), 64'(c_saved));
      end
      if (d_stall) begin
        check("data_hold_valid", 64'(bus.mdata_valid), 64'd1);
        check("data_hold_payload", 64'({bus.mdata_last, bus.mdata}), 64'(d_saved));
      end
      if (first_pending && bus.mcmd_valid) begin
        check("first_cmd_latency", 64'(cyc - start_cyc), 64'd1);
        first_pending = 1'b0;
      end

      start_ok = start && !active;
      if (done_due) begin active = 1'b0; done_due = 1'b0; end
      clr = 1'b0;
      if (start_ok) begin
        active = 1'b1; start_cyc = cyc;
        if (count == '0) begin
          done_due = 1'b1;
        end else begin
          clr = 1'b1; first_pending = 1'b1;
          eff = (len == '0) ? 1 : int'(len);
          for (int k = 0; k < int'(count); k++) begin
            exp_cmd_q.push_back(write ? PZCOREBUS_WRITE_NON_POSTED : PZCOREBUS_READ);
            exp_addr_q.push_back(base + AW'(k * STR));
            exp_len_q.push_back(LW'(eff));
            if (write) begin
              for (int b = 0; b < eff; b++) begin
                exp_data_q.push_back({2{SEED + 32'(k * 256 + b)}});
                exp_last_q.push_back(b == eff - 1);
              end
            end
          end
        end
      end

      bus.scmd_accept  = (acc_mode == 0) || (acc_mode == 1 && cyc % 2 == 1);
      bus.sdata_accept = (acc_mode == 0) || (acc_mode == 1 && cyc % 2 == 0);
      bus.sresp_valid  = 1'b0;
      if (stray_req) begin
        bus.sresp_valid = 1'b1; stray_req = 1'b0;
      end else if (!withhold && resp_q.size() > 0 && resp_q[0] <= cyc) begin
        void'(resp_q.pop_front());
        bus.sresp_valid = 1'b1;
      end
      bus.sresp_last  = bus.sresp_valid;
      bus.sresp_error = bus.sresp_valid && err_mode;

      if (bus.mcmd_valid && bus.scmd_accept) begin
        obs_cmd.push_back(bus.mcmd); obs_addr.push_back(bus.maddr); obs_len.push_back(bus.mlength);
        if (exp_cmd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_cmd: got addr %0h, required no command", bus.maddr);
        end else begin
          ecmd = exp_cmd_q.pop_front();
          check("mcmd", 64'(bus.mcmd), 64'(ecmd));
          check("maddr", 64'(bus.maddr), 64'(exp_addr_q.pop_front()));
          check("mlength", 64'(bus.mlength), 64'(exp_len_q.pop_front()));
          check("mid", 64'(bus.mid), 64'(MIDV));
          m_out++;
          if (ecmd == PZCOREBUS_READ) resp_q.push_back(cyc + RESP_DELAY);
        end
      end
      if (bus.mdata_valid && bus.sdata_accept) begin
        obs_data.push_back(bus.mdata); obs_last.push_back(bus.mdata_last);
        if (exp_data_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_data: got %0h, required no beat", bus.mdata);
        end else begin
          check("mdata", 64'(bus.mdata), 64'(exp_data_q.pop_front()));
          check("mdata_byteen", 64'(bus.mdata_byteen), 64'hFF);
          check("mdata_last", 64'(bus.mdata_last), 64'(exp_last_q[0]));
          if (exp_last_q.pop_front()) resp_q.push_back(cyc + RESP_DELAY);
        end
      end
      c_stall = bus.mcmd_valid && !bus.scmd_accept;
      c_saved = {bus.mcmd, bus.maddr, bus.mlength};
      d_stall = bus.mdata_valid && !bus.sdata_accept;
      d_saved = {bus.mdata_last, bus.mdata};

      if (bus.sresp_valid) begin
        if (m_out > 0) m_out--;
        if (m_rcnt < 65535) m_rcnt++;
        if (err_mode) m_err = 1'b1;
      end
      if (clr) begin m_rcnt = 0; m_err = 1'b0; end
      if (active && !done_due && exp_cmd_q.size() == 0 && exp_data_q.size() == 0 && m_out == 0)
        done_due = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic w, input logic [AW-1:0] b, input logic [CW-1:0] c,
                             input logic [LW-1:0] l);
    write = w; base = b; count = c; len = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, input string name);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < lim) begin step(); i++; end
    n_vec++;
    if (done_cnt == d0) begin
      n_err++;
      $display("FAIL %s: o_done not seen within %0d cycles, required one pulse", name, lim);
    end
    step();
  endtask

  task automatic clear_logs();
    obs_cmd.delete(); obs_addr.delete(); obs_len.delete(); obs_data.delete(); obs_last.delete();
    done_cnt = 0;
  endtask

  initial begin : directed
    rst = 1'b1; start = 1'b0; write = 1'b0; base = '0; count = '0; len = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_resp_count", 64'(rcnt), 64'd0);
    check("rst_error", 64'(err), 64'd0);
    check("rst_mcmd", 64'(bus.mcmd), 64'(PZCOREBUS_NULL_COMMAND));
    check("rst_maddr", 64'(bus.maddr), 64'd0);

    // read x3, always-accept slave
    clear_logs(); acc_mode = 0;
    pulse_start(1'b0, 32'h1000, 16'd3, 8'd4);
    wait_done(200, "read3_done");
    repeat (3) step();
    check("read3_resp_count", 64'(rcnt), 64'd3);
    check("read3_error", 64'(err), 64'd0);
    check("read3_done_pulses", 64'(done_cnt), 64'd1);
    check("read3_ncmd", 64'(obs_addr.size()), 64'd3);
    if (obs_addr.size() == 3) begin
      check("read3_addr0", 64'(obs_addr[0]), 64'h1000);
      check("read3_addr1", 64'(obs_addr[1]), 64'h1040);
      check("read3_addr2", 64'(obs_addr[2]), 64'h1080);
      check("read3_cmd", 64'(obs_cmd[2]), 64'(PZCOREBUS_READ));
      check("read3_len", 64'(obs_len[1]), 64'd4);
    end

    // write x2, length 2, toggling accepts
    clear_logs(); acc_mode = 1;
    pulse_start(1'b1, 32'h2000, 16'd2, 8'd2);
    wait_done(300, "write2_done");
    check("write2_resp_count", 64'(rcnt), 64'd2);
    check("write2_nbeats", 64'(obs_data.size()), 64'd4);
    if (obs_data.size() == 4) begin
      check("write2_beat0", 64'(obs_data[0]), 64'hA5A5_0000_A5A5_0000);
      check("write2_beat1", 64'(obs_data[1]), 64'hA5A5_0001_A5A5_0001);
      check("write2_beat2", 64'(obs_data[2]), 64'hA5A5_0100_A5A5_0100);
      check("write2_beat3", 64'(obs_data[3]), 64'hA5A5_0101_A5A5_0101);
      check("write2_lasts", 64'({obs_last[0], obs_last[1], obs_last[2], obs_last[3]}), 64'b0101);
    end
    if (obs_cmd.size() == 2) begin
      check("write2_cmd", 64'(obs_cmd[0]), 64'(PZCOREBUS_WRITE_NON_POSTED));
      check("write2_addr1", 64'(obs_addr[1]), 64'h2040);
    end

    // read x10 with responses withheld: outstanding cap
    clear_logs(); acc_mode = 0; withhold = 1'b1;
    pulse_start(1'b0, 32'h3000, 16'd10, 8'd1);
    repeat (30) step();
    check("cap_ncmd", 64'(obs_addr.size()), 64'd4);
    check("cap_mcmd_valid", 64'(bus.mcmd_valid), 64'd0);
    check("cap_busy", 64'(busy), 64'd1);
    withhold = 1'b0;
    wait_done(300, "cap_done");
    check("cap_ncmd_final", 64'(obs_addr.size()), 64'd10);
    check("cap_resp_count", 64'(rcnt), 64'd10);

    // write x1 length 0 (one beat) with error response; sticky until next start
    clear_logs(); err_mode = 1'b1;
    pulse_start(1'b1, 32'h4000, 16'd1, 8'd0);
    wait_done(200, "err_done");
    err_mode = 1'b0;
    check("err_set", 64'(err), 64'd1);
    check("err_len", 64'(obs_len.size() == 1 ? obs_len[0] : 8'hFF), 64'd1);
    check("err_single_last", 64'(obs_last.size() == 1 && obs_last[0]), 64'd1);
    repeat (5) step();
    check("err_sticky", 64'(err), 64'd1);
    pulse_start(1'b0, 32'h0, 16'd1, 8'd1);
    check("err_cleared", 64'(err), 64'd0);
    wait_done(200, "err_clear_done");

    // count 0: done next cycle, no traffic
    clear_logs();
    pulse_start(1'b0, 32'h5000, 16'd0, 8'd4);
    check("zero_done", 64'(done), 64'd1);
    step();
    check("zero_done_once", 64'(done), 64'd0);
    check("zero_ncmd", 64'(obs_addr.size()), 64'd0);

    // second start while busy is ignored
    clear_logs(); withhold = 1'b1;
    pulse_start(1'b0, 32'h6000, 16'd2, 8'd1);
    step();
    pulse_start(1'b1, 32'h7000, 16'd5, 8'd3);
    repeat (4) step();
    withhold = 1'b0;
    wait_done(200, "busy_start_done");
    check("busy_start_ncmd", 64'(obs_addr.size()), 64'd2);
    if (obs_addr.size() == 2) begin
      check("busy_start_addr1", 64'(obs_addr[1]), 64'h6040);
      check("busy_start_cmd", 64'(obs_cmd[1]), 64'(PZCOREBUS_READ));
    end
    check("busy_start_resp_count", 64'(rcnt), 64'd2);

    // response outside a sequence still counts; outstanding must not underflow
    stray_req = 1'b1;
    repeat (2) step();
    check("stray_resp_count", 64'(rcnt), 64'd3);
    pulse_start(1'b0, 32'h8000, 16'd2, 8'd2);
    wait_done(200, "after_stray_done");

    // reset with a command pending
    acc_mode = 2;
    pulse_start(1'b0, 32'h9000, 16'd10, 8'd1);
    for (int i = 0; i < 10 && !bus.mcmd_valid; i++) step();
    check("pre_reset_mcmd_valid", 64'(bus.mcmd_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_mcmd_valid", 64'(bus.mcmd_valid), 64'd0);
    check("midrst_mcmd", 64'(bus.mcmd), 64'(PZCOREBUS_NULL_COMMAND));
    check("midrst_mresp_accept", 64'(bus.mresp_accept), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    acc_mode = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pzcorebus_pattern_master.md
Name: pzcorebus_pattern_master

Overview:
- Parametrised successor to the tie-off dummy master.
- When idle, it drives a quiet, protocol-legal pzcorebus master (no commands, no data, responses always accepted).
- On a start pulse, it issues a programmable sequence of read or write commands with stride-incremented addresses, generated write data and response tracking.
- Sits on any pzcorebus master port as a bring-up, BIST or unused-port traffic source; a status interface reports done, response count and errors.

Parameters:
- COUNT_WIDTH, 16, width of command-count and response-count fields.
- MAX_OUTSTANDING, 4, maximum commands issued but not yet responded (1..255).
- ADDR_STRIDE, 64, byte address increment between consecutive commands.
- MID_VALUE, 0, constant driven on mid.
- DATA_SEED, 32'hA5A5_0000, base of the write-data pattern.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_start, input, 1, one-cycle start pulse; ignored unless idle.
- i_write, input, 1, 1 = WRITE (non-posted), 0 = READ; sampled at start.
- i_base_addr, input, ADDRESS_WIDTH, first maddr; sampled at start.
- i_count, input, COUNT_WIDTH, number of commands; 0 = no traffic.
- i_length, input, LENGTH_WIDTH, mlength per command; 0 treated as 1.
- o_busy, output, 1, sequence in progress.
- o_done, output, 1, one-cycle pulse when the sequence completes.
- o_resp_count, output, COUNT_WIDTH, responses received (sresp_valid & sresp_last).
- o_error, output, 1, sticky; set on any accepted response with sresp_error = 1.
- master_if, pzcorebus_if.master, interface, bus port; widths come from the interface.

Behaviour:
- Clock/reset: one clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - mcmd_valid = 0, mdata_valid = 0, mdata_last = 0.
  - mcmd = PZCOREBUS_NULL_COMMAND; maddr, mlength, mparam, minfo, mdata, mdata_byteen = 0.
  - mid = MID_VALUE.
  - mresp_accept = 1 at all times, including during reset.
  - o_busy = 0, o_done = 0, o_resp_count = 0, o_error = 0.
  - FSM state = IDLE.
- States: IDLE, CMD, DATA, DRAIN, DONE.
- IDLE:
  - Bus quiet.
  - On i_start with i_count = 0: go to DONE directly.
  - On i_start with i_count > 0: latch inputs, clear o_resp_count and o_error, set o_busy, go to CMD next cycle.
- CMD:
  - Assert mcmd_valid only while outstanding < MAX_OUTSTANDING.
  - mcmd = PZCOREBUS_WRITE_NON_POSTED or PZCOREBUS_READ.
  - maddr = base + k*ADDR_STRIDE (k = commands issued so far, modulo address width).
  - mlength = effective length.
  - Fields hold stable until scmd_accept.
  - On accept: outstanding++, k++.
    - Write: go to DATA.
    - Read: go to CMD if k < count, else DRAIN.
- DATA:
  - Issue L = effective length beats; mdata_valid held until sdata_accept.
  - Beat b of command k: mdata = DATA_SEED + (k << 8) + b, replicated across data width; mdata_byteen all ones.
  - mdata_last = 1 on beat L-1 only.
  - After last beat is accepted: CMD if k < count, else DRAIN.
  - Commands and data never overlap.
- DRAIN: wait until outstanding = 0, then go to DONE.
- DONE: o_done = 1 for one cycle, o_busy = 0, go to IDLE.
- Response handling:
  - Every cycle, sresp_valid & sresp_last: outstanding--, o_resp_count++ (saturating).
  - sresp_valid & sresp_error: o_error = 1.
  - Simultaneous command accept and final response leaves outstanding unchanged.
  - Responses outside a sequence are accepted and counted against no sequence: o_resp_count still increments, outstanding saturates at 0.
- i_start while busy is ignored; latched parameters remain unchanged.
- Reset mid-sequence: next cycle all outputs at reset values. Any in-flight bus transfer is abandoned; this is acceptable only with a system-wide reset.
- Latency:
  - First mcmd_valid appears 1 cycle after i_start.
  - o_done appears 1 cycle after the final response is accepted, or 1 cycle after i_start when count = 0.

Test Plan:
- Reset while mcmd_valid = 1 -> next cycle mcmd_valid = 0, mcmd = NULL, mresp_accept = 1, o_busy = 0.
- Read, count = 3, base 0x1000, length 4, slave always accepts and responds after 2 cycles -> maddr 0x1000/0x1040/0x1080, mcmd = READ; o_resp_count = 3; o_done pulses once; o_error = 0.
- Write, count = 2, length 2, scmd_accept/sdata_accept toggling 50% -> mdata beats A5A5_0000, A5A5_0001 (last), A5A5_0100, A5A5_0101 (last); payload stable while stalled; 2 responses.
- Read, count = 10, MAX_OUTSTANDING = 4, slave withholds responses -> exactly 4 commands accepted, mcmd_valid stays 0 until a response returns.
- Write, count = 1, slave returns sresp_error = 1 -> o_error = 1 after done and stays set; cleared by the next i_start.
- i_start with count = 0, and a second i_start while busy -> o_done one cycle after start with no bus activity; the second start is ignored.
